pipe_icache: RTL and testbench

PIPE_ICACHE -- requirements
Module: pipe_icache

---
 rtl/pipe_icache.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_icache.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_icache.sv
// ----------------------------------------------------------------------------
// pipe_icache
//   Direct-mapped, read-only instruction cache between the pipeline fetch
//   stage and a word-wide instruction memory. Hits return the addressed word
//   combinationally in the same cycle. Misses refill a whole block, one word
//   per memory completion, before the fetch is retried.
//
//   Parameters
//     SETS      number of direct-mapped sets (power of 2, >= 2)
//     BLKWORDS  32-bit words per block (power of 2, >= 1)
//
//   Ports
//     CLK        clock, rising edge
//     nRST       synchronous active-low reset
//     imemREN    fetch request from the datapath
//     imemaddr   fetch byte address (word aligned)
//     flush      invalidate every entry; aborts a refill in progress
//     ihit       fetch satisfied this cycle
//     imemload   fetched instruction, valid while ihit=1
//     iREN       memory read request
//     iaddr      memory word address (zero when not refilling)
//     iwait      memory busy; a read completes when iREN=1 and iwait=0
//     iload      memory read data
//
//   Optional build macro
//     ICACHE_STATS_EN  adds hit_count / miss_count outputs (32-bit wrapping
//                      counters, cleared only by reset).
//
//   Address split: [1:0] byte, then log2(BLKWORDS) word-offset bits,
//   then log2(SETS) index bits, remaining upper bits are the tag.
// ----------------------------------------------------------------------------
module pipe_icache #(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WOFF_W = $clog2(BLKWORDS);
    localparam int CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - WOFF_W - IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLKWORDS - 1);

    // IDLE : serve hits, detect misses
    // FILL : refill the latched block one word per memory completion
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           r_state;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tags [SETS];
    logic [31:0]      r_data [SETS][BLKWORDS];
    logic [TAG_W-1:0] r_mtag;
    logic [IDX_W-1:0] r_midx;
    logic [CNT_W-1:0] r_cnt;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W-1:0] w_word;
    logic             w_lookup;
    logic             w_hit;
    logic             w_miss;
    logic             w_wr;
    logic             w_last;
    logic [31:0]      w_fill_addr;
    logic             w_unused_byte;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_tag = imemaddr[31 -: TAG_W];
    assign w_idx = imemaddr[2 + WOFF_W +: IDX_W];

    generate
        if (WOFF_W > 0) begin : g_woff
            assign w_word      = imemaddr[2 +: WOFF_W];
            assign w_fill_addr = {r_mtag, r_midx, r_cnt, 2'b00};
        end else begin : g_nowoff
            assign w_word      = '0;
            assign w_fill_addr = {r_mtag, r_midx, 2'b00};
        end
    endgenerate

    // Byte offset is architecturally ignored.
    assign w_unused_byte = ^imemaddr[1:0];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    assign w_lookup = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_hit    = (r_state == IDLE) && imemREN && !flush && w_lookup;
    assign w_miss   = (r_state == IDLE) && imemREN && !flush && !w_lookup;

    // A refill word lands on every memory completion while in FILL.
    assign w_wr     = (r_state == FILL) && !iwait;
    assign w_last   = w_wr && (r_cnt == LAST_WORD);

    assign ihit     = w_hit;
    assign imemload = r_data[w_idx][w_word];
    assign iREN     = (r_state == FILL);
    assign iaddr    = (r_state == FILL) ? w_fill_addr : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Control FSM and valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_cnt   <= '0;
            r_mtag  <= '0;
            r_midx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_miss) begin
                        r_state <= FILL;
                        r_mtag  <= w_tag;
                        r_midx  <= w_idx;
                        r_cnt   <= '0;
                    end
                end
                FILL: begin
                    // Flush takes priority, even over the final completion,
                    // so a block being refilled never becomes valid.
                    if (flush) begin
                        r_valid <= '0;
                        r_state <= IDLE;
                    end else if (!iwait) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_WORD) begin
                            r_valid[r_midx] <= 1'b1;
                            r_state         <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data and tag storage; contents are meaningless until the valid bit
    // is set, so no reset is applied here.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_data[r_midx][r_cnt] <= iload;
        end
        if (w_last) begin
            r_tags[r_midx] <= r_mtag;
        end
    end

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: survive flush, cleared only by reset.
    // ------------------------------------------------------------------
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_pipe_icache.sv
// ----------------------------------------------------------------------------
// tb_pipe_icache
//   Directed bench for pipe_icache (SETS=16, BLKWORDS=2). The memory model
//   returns (address ^ 32'hC0DE0000) for a completed read, so every expected
//   instruction value below is written out by hand from its address.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    // Memory model; returns junk while the memory is busy.
    assign iload = (iREN && !iwait) ? (iaddr ^ 32'hC0DE_0000) : 32'hDEAD_BEEF;

    pipe_icache #(
        .SETS     (16),
        .BLKWORDS (2)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0; iwait = 1'b0;
        adv();
        imemREN = 1'b1; imemaddr = 32'h40;
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit: got %0b want 0", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN: got %0b want 0", iREN); end
        total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
        imemREN = 1'b0;
        nRST = 1'b1;
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL idle_noreq_iREN: got %0b want 0", iREN); end
        adv();
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL cold_req_ihit: got %0b want 0", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL cold_req_iREN: got %0b want 0", iREN); end
        adv();
        imemaddr = 32'h900;   // moving the fetch address must not disturb the fill
        @(negedge CLK);
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL cold_f0_iREN: got %0b want 1", iREN); end
        total++; if (iaddr !== 32'h40) begin bad++; $display("FAIL cold_f0_iaddr: got %h want 00000040", iaddr); end
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL cold_f0_ihit: got %0b want 0", ihit); end
        adv();
        @(negedge CLK);
        total++; if (iaddr !== 32'h44) begin bad++; $display("FAIL cold_f1_iaddr: got %h want 00000044", iaddr); end
        adv();
        imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (ihit !== 1'b1) begin bad++; $display("FAIL cold_hit_ihit: got %0b want 1", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL cold_hit_iREN: got %0b want 0", iREN); end
        total++; if (imemload !== 32'hC0DE_0040) begin bad++; $display("FAIL cold_hit_data: got %h want c0de0040", imemload); end
        adv();
    endtask

    task automatic test_hit_same_cycle();
        imemREN = 1'b1; imemaddr = 32'h44;
        @(negedge CLK);
        total++; if (ihit !== 1'b1) begin bad++; $display("FAIL hit44_ihit: got %0b want 1", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL hit44_iREN: got %0b want 0", iREN); end
        total++; if (imemload !== 32'hC0DE_0044) begin bad++; $display("FAIL hit44_data: got %h want c0de0044", imemload); end
        adv();
        imemREN = 1'b0; imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL noreq_ihit: got %0b want 0", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL noreq_iREN: got %0b want 0", iREN); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL noreq_stay_iREN: got %0b want 0", iREN); end
        adv();
    endtask

    task automatic test_conflict();
        imemREN = 1'b1; imemaddr = 32'h840;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL conf_req_ihit: got %0b want 0", ihit); end
        adv();
        @(negedge CLK);
        total++; if (iaddr !== 32'h840) begin bad++; $display("FAIL conf_f0_iaddr: got %h want 00000840", iaddr); end
        adv();
        @(negedge CLK);
        total++; if (iaddr !== 32'h844) begin bad++; $display("FAIL conf_f1_iaddr: got %h want 00000844", iaddr); end
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1) begin bad++; $display("FAIL conf_hit_ihit: got %0b want 1", ihit); end
        total++; if (imemload !== 32'hC0DE_0840) begin bad++; $display("FAIL conf_hit_data: got %h want c0de0840", imemload); end
        adv();
        imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL conf_evict_ihit: got %0b want 0", ihit); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL conf_refill_iREN: got %0b want 1", iREN); end
        total++; if (iaddr !== 32'h40) begin bad++; $display("FAIL conf_refill_iaddr: got %h want 00000040", iaddr); end
        adv();
        adv();
        @(negedge CLK);
        total++; if (imemload !== 32'hC0DE_0040 || ihit !== 1'b1) begin bad++; $display("FAIL conf_rehit: got ihit=%0b data=%h want ihit=1 data=c0de0040", ihit, imemload); end
        adv();
    endtask

    task automatic test_iwait();
        imemREN = 1'b1; imemaddr = 32'h80;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL wait_req_ihit: got %0b want 0", ihit); end
        adv();
        iwait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++; if (iaddr !== 32'h80 || iREN !== 1'b1) begin bad++; $display("FAIL wait_hold%0d: got iREN=%0b iaddr=%h want iREN=1 iaddr=00000080", k, iREN, iaddr); end
            adv();
        end
        iwait = 1'b0;
        @(negedge CLK);
        total++; if (iaddr !== 32'h80) begin bad++; $display("FAIL wait_release_iaddr: got %h want 00000080", iaddr); end
        adv();
        @(negedge CLK);
        total++; if (iaddr !== 32'h84) begin bad++; $display("FAIL wait_w1_iaddr: got %h want 00000084", iaddr); end
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0080) begin bad++; $display("FAIL wait_hit80: got ihit=%0b data=%h want ihit=1 data=c0de0080", ihit, imemload); end
        adv();
        imemaddr = 32'h84;
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0084) begin bad++; $display("FAIL wait_hit84: got ihit=%0b data=%h want ihit=1 data=c0de0084", ihit, imemload); end
        adv();
    endtask

    task automatic test_flush_fill();
        imemREN = 1'b1; imemaddr = 32'hC0;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL ffill_req_ihit: got %0b want 0", ihit); end
        adv();
        flush = 1'b1;
        @(negedge CLK);
        total++; if (iREN !== 1'b1 || iaddr !== 32'hC0) begin bad++; $display("FAIL ffill_f0: got iREN=%0b iaddr=%h want iREN=1 iaddr=000000c0", iREN, iaddr); end
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL ffill_ihit: got %0b want 0", ihit); end
        adv();
        flush = 1'b0; imemaddr = 32'h40;
        @(negedge CLK);
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL ffill_abort_iREN: got %0b want 0", iREN); end
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL ffill_40_ihit: got %0b want 0", ihit); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin bad++; $display("FAIL ffill_40_refill: got iREN=%0b iaddr=%h want iREN=1 iaddr=00000040", iREN, iaddr); end
        adv();
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0040) begin bad++; $display("FAIL ffill_40_hit: got ihit=%0b data=%h want ihit=1 data=c0de0040", ihit, imemload); end
        adv();
        imemaddr = 32'h80;   // flush also dropped the 0x80 block
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL ffill_80_ihit: got %0b want 0", ihit); end
        adv();
        adv();
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0080) begin bad++; $display("FAIL ffill_80_hit: got ihit=%0b data=%h want ihit=1 data=c0de0080", ihit, imemload); end
        adv();
    endtask

    task automatic test_flush_final();
        imemREN = 1'b1; imemaddr = 32'hC0;
        adv();
        adv();
        flush = 1'b1;
        @(negedge CLK);
        total++; if (iaddr !== 32'hC4) begin bad++; $display("FAIL ffin_last_iaddr: got %h want 000000c4", iaddr); end
        adv();
        flush = 1'b0;
        @(negedge CLK);
        total++; if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL ffin_after: got ihit=%0b iREN=%0b want ihit=0 iREN=0", ihit, iREN); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1 || iaddr !== 32'hC0) begin bad++; $display("FAIL ffin_refill: got iREN=%0b iaddr=%h want iREN=1 iaddr=000000c0", iREN, iaddr); end
        adv();
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_00C0) begin bad++; $display("FAIL ffin_hit: got ihit=%0b data=%h want ihit=1 data=c0de00c0", ihit, imemload); end
        adv();
    endtask

    task automatic test_flush_idle();
        imemREN = 1'b1; imemaddr = 32'hC0; flush = 1'b1;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL fidle_ihit: got %0b want 0", ihit); end
        total++; if (iREN !== 1'b0) begin bad++; $display("FAIL fidle_iREN: got %0b want 0", iREN); end
        adv();
        flush = 1'b0;
        @(negedge CLK);
        total++; if (ihit !== 1'b0) begin bad++; $display("FAIL fidle_after_ihit: got %0b want 0", ihit); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL fidle_refill_iREN: got %0b want 1", iREN); end
        adv();
        adv();
        imemREN = 1'b0;
        adv();
    endtask

    task automatic test_reset_midfill();
        imemREN = 1'b1; imemaddr = 32'h80;
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1) begin bad++; $display("FAIL rmid_fill_iREN: got %0b want 1", iREN); end
        nRST = 1'b0;
        adv();
        nRST = 1'b1;
        @(negedge CLK);
        total++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin bad++; $display("FAIL rmid_after: got iREN=%0b iaddr=%h ihit=%0b want 0/00000000/0", iREN, iaddr, ihit); end
        adv();
        @(negedge CLK);
        total++; if (iREN !== 1'b1 || iaddr !== 32'h80) begin bad++; $display("FAIL rmid_refill: got iREN=%0b iaddr=%h want iREN=1 iaddr=00000080", iREN, iaddr); end
        adv();
        adv();
        @(negedge CLK);
        total++; if (ihit !== 1'b1 || imemload !== 32'hC0DE_0080) begin bad++; $display("FAIL rmid_hit: got ihit=%0b data=%h want ihit=1 data=c0de0080", ihit, imemload); end
        adv();
        imemREN = 1'b0;
        adv();
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        nRST = 1'b0; imemREN = 1'b0; flush = 1'b0;
        adv();
        nRST = 1'b1;
        @(negedge CLK);
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL stats_reset: got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
        imemREN = 1'b1; imemaddr = 32'h40;
        adv();
        adv();
        adv();
        adv();
        adv();
        adv();
        imemREN = 1'b0;
        @(negedge CLK);
        total++; if (hit_count !== 32'd3 || miss_count !== 32'd1) begin bad++; $display("FAIL stats_count: got hit=%0d miss=%0d want 3/1", hit_count, miss_count); end
        flush = 1'b1;
        adv();
        flush = 1'b0;
        @(negedge CLK);
        total++; if (hit_count !== 32'd3 || miss_count !== 32'd1) begin bad++; $display("FAIL stats_flush: got hit=%0d miss=%0d want 3/1", hit_count, miss_count); end
        adv();
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_same_cycle();
        test_conflict();
        test_iwait();
        test_flush_fill();
        test_flush_final();
        test_flush_idle();
        test_reset_midfill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
